// File: rtl/tlp_recv.sv
// RX TLP decoder: turns CPU register MWr32/MRd32 into Action records and forwards CplD payload on c2f.
// Optional error counter output enabled by defining TLP_RECV_ERRCNT_EN.
package tlp_xcvr_pkg;
  localparam int ACT_CHAN_W = 7;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_WRITE = 2'd1,
    ACT_READ  = 2'd2
  } ActType;

  typedef struct packed {
    ActType                typ;
    logic [ACT_CHAN_W-1:0] chan;
    logic [15:0]           reqID;
    logic [7:0]            tag;
    logic [31:0]           data;
  } Action;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_HDR,
    S_WR_DATA,
    S_RD_HDR,
    S_ACT,
    S_CMP_HDR,
    S_CMP_DATA,
    S_DISCARD
  } RecvState;
endpackage

module tlp_recv
  import tlp_xcvr_pkg::*;
#(
  parameter int CHAN_BITS  = 7,
  parameter int MAX_CMP_DW = 32
) (
  input  logic        pcieClk_in,
  input  logic        pcieRst_in,
  input  logic [63:0] rxData_in,
  input  logic        rxValid_in,
  output logic        rxReady_out,
  input  logic        rxSOP_in,
  input  logic        rxEOP_in,
  output Action       actData_out,
  output logic        actValid_out,
  input  logic        actReady_in,
  output logic [63:0] c2fData_out,
  output logic        c2fValid_out,
  input  logic        c2fReady_in,
  output RecvState    stateDbg_out
`ifdef TLP_RECV_ERRCNT_EN
  ,
  output logic [15:0] errCount_out
`endif
);

  localparam int QW_W = $clog2(MAX_CMP_DW / 2 + 1);

  // Every stream moves one word on a clock edge where valid && ready; a source holds
  // data stable while valid is high and not yet accepted, and never retracts valid.

  RecvState              state;
  logic [QW_W-1:0]       qwCount;
  Action                 act;

  logic [1:0]            fmt;
  logic [4:0]            typ;
  logic [9:0]            len;
  logic [2:0]            cplStatus;
  logic [CHAN_BITS-1:0]  chanField;
  logic                  rxXfer;
  logic                  isMwr;
  logic                  isMrd;
  logic                  isCpl;

  assign fmt       = rxData_in[30:29];
  assign typ       = rxData_in[28:24];
  assign len       = rxData_in[9:0];
  assign cplStatus = rxData_in[47:45];
  assign chanField = rxData_in[CHAN_BITS+1:2];

  // A zero length field encodes 1024 DWs, which always exceeds the completion limit.
  assign isMwr = (fmt == 2'b10) && (typ == 5'b00000) && (len == 10'd1);
  assign isMrd = (fmt == 2'b00) && (typ == 5'b00000) && (len == 10'd1);
  assign isCpl = (fmt == 2'b10) && (typ == 5'b01010) && (cplStatus == 3'd0) &&
                 !len[0] && (len != 10'd0) && (len <= 10'(MAX_CMP_DW));

  always_comb begin
    rxReady_out = 1'b0;
    if (!pcieRst_in) begin
      case (state)
        S_ACT:      rxReady_out = 1'b0;
        S_CMP_DATA: rxReady_out = c2fReady_in;
        default:    rxReady_out = 1'b1;
      endcase
    end
  end

  assign rxXfer       = rxValid_in && rxReady_out;
  assign c2fValid_out = !pcieRst_in && (state == S_CMP_DATA) && rxValid_in;
  assign c2fData_out  = rxData_in;
  assign actValid_out = !pcieRst_in && (state == S_ACT);
  assign actData_out  = act;
  assign stateDbg_out = state;

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      state   <= S_IDLE;
      qwCount <= '0;
      act     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rxXfer && rxSOP_in) begin
            act.reqID <= rxData_in[63:48];
            act.tag   <= rxData_in[47:40];
            if (rxEOP_in) begin
              state <= S_IDLE;
            end else if (isMwr) begin
              state <= S_WR_HDR;
            end else if (isMrd) begin
              state <= S_RD_HDR;
            end else if (isCpl) begin
              qwCount <= QW_W'(len[9:1]);
              state   <= S_CMP_HDR;
            end else begin
              state <= S_DISCARD;
            end
          end
        end
        S_WR_HDR: begin
          if (rxXfer) begin
            act.typ  <= ACT_WRITE;
            act.chan <= ACT_CHAN_W'(chanField);
            act.data <= rxData_in[63:32];
            // Address bit 2 set puts the payload DW next to the address in this QW.
            if (rxData_in[2]) begin
              state <= rxEOP_in ? S_ACT : S_DISCARD;
            end else begin
              state <= rxEOP_in ? S_IDLE : S_WR_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (rxXfer) begin
            act.data <= rxData_in[31:0];
            state    <= rxEOP_in ? S_ACT : S_DISCARD;
          end
        end
        S_RD_HDR: begin
          if (rxXfer) begin
            act.typ  <= ACT_READ;
            act.chan <= ACT_CHAN_W'(chanField);
            act.data <= '0;
            state    <= rxEOP_in ? S_ACT : S_DISCARD;
          end
        end
        S_ACT: begin
          if (actReady_in) begin
            state <= S_IDLE;
          end
        end
        S_CMP_HDR: begin
          if (rxXfer) begin
            if (rxEOP_in) begin
              state <= S_IDLE;
            end else if (rxData_in[2]) begin
              state <= S_DISCARD;
            end else begin
              state <= S_CMP_DATA;
            end
          end
        end
        S_CMP_DATA: begin
          if (rxXfer) begin
            qwCount <= qwCount - QW_W'(1);
            if (rxEOP_in) begin
              state <= S_IDLE;
            end else if (qwCount == QW_W'(1)) begin
              state <= S_DISCARD;
            end
          end
        end
        S_DISCARD: begin
          if (rxXfer && rxEOP_in) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TLP_RECV_ERRCNT_EN
  logic dropEvent;

  // One pulse per TLP that is dropped or abandoned, on the QW that decides its fate.
  always_comb begin
    dropEvent = 1'b0;
    if (rxXfer) begin
      case (state)
        S_IDLE:     dropEvent = rxSOP_in && (rxEOP_in || !(isMwr || isMrd || isCpl));
        S_WR_HDR:   dropEvent = rxData_in[2] ? !rxEOP_in : rxEOP_in;
        S_WR_DATA:  dropEvent = !rxEOP_in;
        S_RD_HDR:   dropEvent = !rxEOP_in;
        S_CMP_HDR:  dropEvent = rxEOP_in || rxData_in[2];
        S_CMP_DATA: dropEvent = rxEOP_in ? (qwCount != QW_W'(1)) : (qwCount == QW_W'(1));
        default:    dropEvent = 1'b0;
      endcase
    end
  end

  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      errCount_out <= '0;
    end else if (dropEvent && (errCount_out != 16'hFFFF)) begin
      errCount_out <= errCount_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tlp_recv.sv
// Directed bench for tlp_recv: drivers push expected actions / payload QWs, a negedge monitor checks them.
module tb_tlp_recv;
  import tlp_xcvr_pkg::*;

  localparam int ACT_W = $bits(Action);

  logic        pcieClk_in;
  logic        pcieRst_in;
  logic [63:0] rxData_in;
  logic        rxValid_in;
  logic        rxReady_out;
  logic        rxSOP_in;
  logic        rxEOP_in;
  Action       actData_out;
  logic        actValid_out;
  logic        actReady_in;
  logic [63:0] c2fData_out;
  logic        c2fValid_out;
  logic        c2fReady_in;
  RecvState    stateDbg_out;
`ifdef TLP_RECV_ERRCNT_EN
  logic [15:0] errCount_out;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic tog_en = 1'b0;

  logic [ACT_W-1:0] exp_q[$];
  logic [63:0]      c2f_q[$];

  tlp_recv dut (
    .pcieClk_in   (pcieClk_in),
    .pcieRst_in   (pcieRst_in),
    .rxData_in    (rxData_in),
    .rxValid_in   (rxValid_in),
    .rxReady_out  (rxReady_out),
    .rxSOP_in     (rxSOP_in),
    .rxEOP_in     (rxEOP_in),
    .actData_out  (actData_out),
    .actValid_out (actValid_out),
    .actReady_in  (actReady_in),
    .c2fData_out  (c2fData_out),
    .c2fValid_out (c2fValid_out),
    .c2fReady_in  (c2fReady_in),
    .stateDbg_out (stateDbg_out)
`ifdef TLP_RECV_ERRCNT_EN
    ,
    .errCount_out (errCount_out)
`endif
  );

  // clock / reset
  initial pcieClk_in = 1'b0;
  always #4 pcieClk_in = ~pcieClk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] hdr0(input logic [1:0] fmt, input logic [4:0] typ,
                                      input logic [9:0] len, input logic [31:0] dw1);
    return {dw1, 1'b0, fmt, typ, 14'd0, len};
  endfunction

  function automatic Action mk_act(input ActType t, input logic [6:0] ch, input logic [15:0] rid,
                                   input logic [7:0] tg, input logic [31:0] d);
    Action a;
    a.typ   = t;
    a.chan  = ch;
    a.reqID = rid;
    a.tag   = tg;
    a.data  = d;
    return a;
  endfunction

  // driver: called just after a posedge, returns just after the accepting posedge
  task automatic send_qw(input logic [63:0] d, input logic sop, input logic eop);
    int   waited = 0;
    logic ok = 1'b0;
    rxData_in  = d;
    rxSOP_in   = sop;
    rxEOP_in   = eop;
    rxValid_in = 1'b1;
    while (!ok && waited < 200) begin
      @(negedge pcieClk_in);
      ok = rxReady_out;
      @(posedge pcieClk_in);
      #1;
      waited++;
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL rx_handshake: got no rxReady_out in %0d cycles required accept", waited);
    end
    rxValid_in = 1'b0;
    rxSOP_in   = 1'b0;
    rxEOP_in   = 1'b0;
  endtask

  // c2f back-pressure pattern
  initial begin
    c2fReady_in = 1'b1;
    forever begin
      @(posedge pcieClk_in);
      #1;
      c2fReady_in = tog_en ? ~c2fReady_in : 1'b1;
    end
  end

  // scoreboard monitor
  always @(negedge pcieClk_in) begin
    if (!pcieRst_in) begin
      if (actValid_out && actReady_in) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL act_unexpected: got %0h required none", actData_out);
        end else begin
          check("act", 128'(actData_out), 128'(exp_q.pop_front()));
        end
      end
      if (c2fValid_out && c2fReady_in) begin
        if (c2f_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL c2f_unexpected: got %0h required none", c2fData_out);
        end else begin
          check("c2f", 128'(c2fData_out), 128'(c2f_q.pop_front()));
        end
      end
    end
  end

  initial begin
    Action hold_exp;
    pcieRst_in  = 1'b1;
    rxData_in   = '0;
    rxValid_in  = 1'b0;
    rxSOP_in    = 1'b0;
    rxEOP_in    = 1'b0;
    actReady_in = 1'b1;

    repeat (2) @(negedge pcieClk_in);
    check("rst_rxReady", 128'(rxReady_out), 128'(0));
    check("rst_actValid", 128'(actValid_out), 128'(0));
    check("rst_c2fValid", 128'(c2fValid_out), 128'(0));
    check("rst_state", 128'(stateDbg_out), 128'(S_IDLE));
    @(posedge pcieClk_in);
    #1;
    pcieRst_in = 1'b0;
    @(negedge pcieClk_in);
    check("idle_rxReady", 128'(rxReady_out), 128'(1));
    @(posedge pcieClk_in);
    #1;

    // MWr32 with data in QW1 high DW
    exp_q.push_back(mk_act(ACT_WRITE, 7'd5, 16'h0100, 8'h05, 32'hCAFEF00D));
    send_qw(hdr0(2'b10, 5'd0, 10'd1, 32'h0100_050F), 1'b1, 1'b0);
    send_qw(64'hCAFEF00D_00000014, 1'b0, 1'b1);

    // MWr32 with data in QW2, consumer stalls for 10 cycles
    hold_exp = mk_act(ACT_WRITE, 7'd4, 16'h0300, 8'h07, 32'h12345678);
    exp_q.push_back(hold_exp);
    send_qw(hdr0(2'b10, 5'd0, 10'd1, 32'h0300_070F), 1'b1, 1'b0);
    actReady_in = 1'b0;
    send_qw(64'h00000000_00000010, 1'b0, 1'b0);
    send_qw(64'h00000000_12345678, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge pcieClk_in);
      check("hold_actValid", 128'(actValid_out), 128'(1));
      check("hold_rxReady", 128'(rxReady_out), 128'(0));
      check("hold_actData", 128'(actData_out), 128'(hold_exp));
    end
    @(posedge pcieClk_in);
    #1;
    actReady_in = 1'b1;

    // MRd32
    exp_q.push_back(mk_act(ACT_READ, 7'd2, 16'h0200, 8'h1F, 32'h0));
    send_qw(hdr0(2'b00, 5'd0, 10'd1, 32'h0200_1F0F), 1'b1, 1'b0);
    send_qw(64'h00000000_00000008, 1'b0, 1'b1);

    // CplD 32 DW with toggling back-pressure
    tog_en = 1'b1;
    send_qw(hdr0(2'b10, 5'b01010, 10'd32, 32'h0000_0080), 1'b1, 1'b0);
    send_qw(64'h00000000_01000900, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      c2f_q.push_back(64'hA5A5_0000_0000_0000 + 64'(i));
      send_qw(64'hA5A5_0000_0000_0000 + 64'(i), 1'b0, (i == 15));
    end
    tog_en = 1'b0;
    @(negedge pcieClk_in);
    check("cpl_state_idle", 128'(stateDbg_out), 128'(S_IDLE));
    check("cpl_all_drained", 128'(c2f_q.size()), 128'(0));
    @(posedge pcieClk_in);
    #1;

    // dropped: MWr32 length 2, 4DW MWr, CplD with status 1
    send_qw(hdr0(2'b10, 5'd0, 10'd2, 32'h0100_010F), 1'b1, 1'b0);
    send_qw(64'h11111111_00000014, 1'b0, 1'b0);
    send_qw(64'h00000000_22222222, 1'b0, 1'b1);
    send_qw(hdr0(2'b11, 5'd0, 10'd1, 32'h0100_020F), 1'b1, 1'b0);
    send_qw(64'h00000014_00000001, 1'b0, 1'b0);
    send_qw(64'h00000000_33333333, 1'b0, 1'b1);
    send_qw(hdr0(2'b10, 5'b01010, 10'd2, 32'h0000_2008), 1'b1, 1'b0);
    send_qw(64'h00000000_01000300, 1'b0, 1'b0);
    send_qw(64'h44444444_44444444, 1'b0, 1'b1);
`ifdef TLP_RECV_ERRCNT_EN
    @(negedge pcieClk_in);
    check("err_count", 128'(errCount_out), 128'(3));
    @(posedge pcieClk_in);
    #1;
`endif

    // early EOP on MWr, misaligned CplD, oversize CplD: all dropped
    send_qw(hdr0(2'b10, 5'd0, 10'd1, 32'h0100_030F), 1'b1, 1'b0);
    send_qw(64'h00000000_00000010, 1'b0, 1'b1);
    send_qw(hdr0(2'b10, 5'b01010, 10'd2, 32'h0000_0008), 1'b1, 1'b0);
    send_qw(64'h00000000_01000404, 1'b0, 1'b0);
    send_qw(64'h55555555_55555555, 1'b0, 1'b1);
    send_qw(hdr0(2'b10, 5'b01010, 10'd34, 32'h0000_0088), 1'b1, 1'b0);
    send_qw(64'h00000000_01000500, 1'b0, 1'b0);
    send_qw(64'h66666666_66666666, 1'b0, 1'b1);
    @(negedge pcieClk_in);
    check("drop_state_idle", 128'(stateDbg_out), 128'(S_IDLE));
    @(posedge pcieClk_in);
    #1;

    // reset in the middle of a CplD after 5 payload QWs
    send_qw(hdr0(2'b10, 5'b01010, 10'd16, 32'h0000_0040), 1'b1, 1'b0);
    send_qw(64'h00000000_01000600, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      c2f_q.push_back(64'hBEEF_0000_0000_0000 + 64'(i));
      send_qw(64'hBEEF_0000_0000_0000 + 64'(i), 1'b0, 1'b0);
    end
    rxData_in  = 64'hBEEF_0000_0000_0005;
    rxValid_in = 1'b1;
    pcieRst_in = 1'b1;
    @(negedge pcieClk_in);
    check("midrst_rxReady", 128'(rxReady_out), 128'(0));
    @(posedge pcieClk_in);
    #1;
    pcieRst_in = 1'b0;
    @(negedge pcieClk_in);
    check("midrst_c2fValid", 128'(c2fValid_out), 128'(0));
    check("midrst_state", 128'(stateDbg_out), 128'(S_IDLE));
    @(posedge pcieClk_in);
    #1;
    send_qw(64'hBEEF_0000_0000_0006, 1'b0, 1'b0);
    send_qw(64'hBEEF_0000_0000_0007, 1'b0, 1'b1);
    exp_q.push_back(mk_act(ACT_READ, 7'd7, 16'h0400, 8'h22, 32'h0));
    send_qw(hdr0(2'b00, 5'd0, 10'd1, 32'h0400_220F), 1'b1, 1'b0);
    send_qw(64'h00000000_0000001C, 1'b0, 1'b1);

    repeat (5) @(negedge pcieClk_in);
    check("act_queue_empty", 128'(exp_q.size()), 128'(0));
    check("c2f_queue_empty", 128'(c2f_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
